perf_monitor_reg_arb: RTL and testbench

Round-robin arbiter that shares the monitor's single register-interface configuration port among NUM_REQ requesters, such as a host programming path, a debug path and an internal snapshot engine. It sits between the requesters and the counter register file. It accepts one request at a time, latches it and presents it on the shared bus until the slave completes. It then returns the response only to the requester that issued it.

---
 rtl/perf_monitor_reg_arb.sv | 186 ++++++++++++++++++
 tb/tb_perf_monitor_reg_arb.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_monitor_reg_arb.sv
// perf_monitor_reg_arb: round-robin arbiter for the shared register configuration port.
// One requester is latched at a time and its payload is held on the shared bus until the
// slave completes. The response is then returned only to the requester that issued it.
// Optional macro PERF_MON_REG_ARB_TIMEOUT_EN: when defined, a wait counter forces an error
// completion after TIMEOUT_CYCLES BUSY cycles without mst_ready_i. When it is undefined,
// BUSY waits indefinitely for the slave.
module perf_monitor_reg_arb #(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    input  logic [NUM_REQ-1:0]                req_write_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata_i,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_wstrb_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    output logic [DATA_WIDTH-1:0]             req_rdata_o,
    output logic                              req_error_o,
    output logic                              mst_valid_o,
    output logic                              mst_write_o,
    output logic [ADDR_WIDTH-1:0]             mst_addr_o,
    output logic [DATA_WIDTH-1:0]             mst_wdata_o,
    output logic [DATA_WIDTH/8-1:0]           mst_wstrb_o,
    input  logic                              mst_ready_i,
    input  logic [DATA_WIDTH-1:0]             mst_rdata_i,
    input  logic                              mst_error_i,
    output logic                              busy_o
);

    localparam int unsigned IdxW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned StrbW = DATA_WIDTH / 8;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    state_e                 r_state;
    state_e                 w_state_next;

    logic [IdxW-1:0]        r_rr_ptr;
    logic [IdxW-1:0]        r_grant;
    logic                   r_mst_write;
    logic [ADDR_WIDTH-1:0]  r_mst_addr;
    logic [DATA_WIDTH-1:0]  r_mst_wdata;
    logic [StrbW-1:0]       r_mst_wstrb;

    logic                   w_any_valid;
    logic [IdxW-1:0]        w_sel;
    logic [IdxW-1:0]        w_scan_idx;
    int unsigned            w_scan;
    logic                   w_accept;
    logic                   w_done;
    logic                   w_timeout;
    logic [IdxW-1:0]        w_rr_next;

    // Round-robin pick: first valid requester scanning upward from r_rr_ptr, with wrap.
    always_comb begin
        w_any_valid = 1'b0;
        w_sel       = '0;
        w_scan      = 0;
        w_scan_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_scan = int'(r_rr_ptr) + k;
            if (w_scan >= NUM_REQ) begin
                w_scan = w_scan - NUM_REQ;
            end
            w_scan_idx = IdxW'(w_scan);
            if (!w_any_valid && req_valid_i[w_scan_idx]) begin
                w_any_valid = 1'b1;
                w_sel       = w_scan_idx;
            end
        end
    end

    assign w_accept  = (r_state == StIdle) && w_any_valid;
    assign w_rr_next = (r_grant == LastIdx) ? '0 : r_grant + 1'b1;

`ifdef PERF_MON_REG_ARB_TIMEOUT_EN
    localparam logic [15:0] TimeoutVal = 16'(TIMEOUT_CYCLES);

    logic [15:0] r_wait_cnt;

    // Wait counter: held at zero in IDLE so every BUSY period starts from zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wait_cnt <= '0;
        end else if (r_state == StIdle) begin
            r_wait_cnt <= '0;
        end else if (!mst_ready_i && (r_wait_cnt != TimeoutVal)) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and completion decode; a real slave response beats the timeout.
    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_any_valid) begin
                    w_state_next = StBusy;
                end
            end
            StBusy: begin
                if (mst_ready_i) begin
                    w_done       = 1'b1;
                    w_state_next = StIdle;
                end
`ifdef PERF_MON_REG_ARB_TIMEOUT_EN
                else if (r_wait_cnt == TimeoutVal) begin
                    w_done       = 1'b1;
                    w_timeout    = 1'b1;
                    w_state_next = StIdle;
                end
`endif
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Grant, round-robin pointer and latched bus payload.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_mst_write <= 1'b0;
            r_mst_addr  <= '0;
            r_mst_wdata <= '0;
            r_mst_wstrb <= '0;
        end else begin
            if (w_accept) begin
                r_grant     <= w_sel;
                r_mst_write <= req_write_i[w_sel];
                r_mst_addr  <= req_addr_i[w_sel*ADDR_WIDTH +: ADDR_WIDTH];
                r_mst_wdata <= req_wdata_i[w_sel*DATA_WIDTH +: DATA_WIDTH];
                r_mst_wstrb <= req_wstrb_i[w_sel*StrbW +: StrbW];
            end
            if (w_done) begin
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    // Response routing: only the granted requester sees the pulse; data is zero otherwise.
    always_comb begin
        req_ready_o = '0;
        req_rdata_o = '0;
        req_error_o = 1'b0;
        if (w_done) begin
            req_ready_o = NUM_REQ'(1) << r_grant;
            if (w_timeout) begin
                req_error_o = 1'b1;
            end else begin
                req_rdata_o = mst_rdata_i;
                req_error_o = mst_error_i;
            end
        end
    end

    assign mst_valid_o = (r_state == StBusy);
    assign busy_o      = (r_state == StBusy);
    assign mst_write_o = r_mst_write;
    assign mst_addr_o  = r_mst_addr;
    assign mst_wdata_o = r_mst_wdata;
    assign mst_wstrb_o = r_mst_wstrb;

endmodule

// File: tb/tb_perf_monitor_reg_arb.sv
// Self-checking bench for perf_monitor_reg_arb (NUM_REQ=3, 32-bit address/data).
// Timeout sequence runs only when PERF_MON_REG_ARB_TIMEOUT_EN is defined.
module tb_perf_monitor_reg_arb;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic            clk_i;
    logic            rst_ni;
    logic [N-1:0]    req_valid_i;
    logic [N-1:0]    req_write_i;
    logic [N*AW-1:0] req_addr_i;
    logic [N*DW-1:0] req_wdata_i;
    logic [N*SW-1:0] req_wstrb_i;
    logic [N-1:0]    req_ready_o;
    logic [DW-1:0]   req_rdata_o;
    logic            req_error_o;
    logic            mst_valid_o;
    logic            mst_write_o;
    logic [AW-1:0]   mst_addr_o;
    logic [DW-1:0]   mst_wdata_o;
    logic [SW-1:0]   mst_wstrb_o;
    logic            mst_ready_i;
    logic [DW-1:0]   mst_rdata_i;
    logic            mst_error_i;
    logic            busy_o;

    perf_monitor_reg_arb #(
        .NUM_REQ        (N),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (8)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_wstrb_i (req_wstrb_i),
        .req_ready_o (req_ready_o),
        .req_rdata_o (req_rdata_o),
        .req_error_o (req_error_o),
        .mst_valid_o (mst_valid_o),
        .mst_write_o (mst_write_o),
        .mst_addr_o  (mst_addr_o),
        .mst_wdata_o (mst_wdata_o),
        .mst_wstrb_o (mst_wstrb_o),
        .mst_ready_i (mst_ready_i),
        .mst_rdata_i (mst_rdata_i),
        .mst_error_i (mst_error_i),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Per-requester payload held by the bench
    logic          p_write [N];
    logic [AW-1:0] p_addr  [N];
    logic [DW-1:0] p_wdata [N];
    logic [SW-1:0] p_wstrb [N];

    typedef struct {
        logic [N-1:0] mask;
        logic         wr;
        int           waits;
        logic         err;
        logic [DW-1:0] rdata;
        int           exp_grant;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req_write_i[i]          = p_write[i];
            req_addr_i[i*AW +: AW]  = p_addr[i];
            req_wdata_i[i*DW +: DW] = p_wdata[i];
            req_wstrb_i[i*SW +: SW] = p_wstrb[i];
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid_i = '0;
        mst_ready_i = 1'b0;
        mst_rdata_i = '0;
        mst_error_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clear_inputs();
        #2;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic set_fixed_payload();
        p_addr[0] = 32'h20; p_addr[1] = 32'h24; p_addr[2] = 32'h28;
        p_wdata[0] = 32'hA0; p_wdata[1] = 32'hB0; p_wdata[2] = 32'hC0;
        p_wstrb[0] = 4'hF; p_wstrb[1] = 4'h3; p_wstrb[2] = 4'hC;
        for (int i = 0; i < N; i++) p_write[i] = 1'b0;
        apply();
    endtask

    // One full transaction from an IDLE cycle to the following IDLE cycle.
    task automatic run_vec(input vec_t v, input int idx);
        logic [N-1:0] exp_rdy;
        exp_rdy = N'(1) << v.exp_grant;
        for (int i = 0; i < N; i++) p_write[i] = v.wr;
        apply();
        req_valid_i = v.mask;
        mst_ready_i = 1'b0;
        #1;
        check($sformatf("v%0d_idle", idx), 64'(busy_o), 64'd0);
        tick();
        check($sformatf("v%0d_valid", idx), 64'(mst_valid_o), 64'd1);
        check($sformatf("v%0d_addr", idx), 64'(mst_addr_o), 64'(p_addr[v.exp_grant]));
        check($sformatf("v%0d_wdata", idx), 64'(mst_wdata_o), 64'(p_wdata[v.exp_grant]));
        check($sformatf("v%0d_wstrb", idx), 64'(mst_wstrb_o), 64'(p_wstrb[v.exp_grant]));
        check($sformatf("v%0d_write", idx), 64'(mst_write_o), 64'(v.wr));
        for (int w = 0; w < v.waits; w++) begin
            check($sformatf("v%0d_w%0d_rdy", idx, w), 64'(req_ready_o), 64'd0);
            check($sformatf("v%0d_w%0d_addr", idx, w), 64'(mst_addr_o),
                  64'(p_addr[v.exp_grant]));
            tick();
        end
        mst_ready_i = 1'b1;
        mst_rdata_i = v.rdata;
        mst_error_i = v.err;
        #1;
        check($sformatf("v%0d_ready", idx), 64'(req_ready_o), 64'(exp_rdy));
        check($sformatf("v%0d_rdata", idx), 64'(req_rdata_o), 64'(v.rdata));
        check($sformatf("v%0d_err", idx), 64'(req_error_o), 64'(v.err));
        check($sformatf("v%0d_hold", idx), 64'(mst_wdata_o), 64'(p_wdata[v.exp_grant]));
        tick();
        clear_inputs();
        #1;
        check($sformatf("v%0d_done_busy", idx), 64'(busy_o), 64'd0);
        check($sformatf("v%0d_done_rdy", idx), 64'(req_ready_o), 64'd0);
    endtask

    vec_t vecs [9];

    // Reference model state for the random phase
    bit          pend [N];
    bit          m_busy;
    int          m_rr;
    int          m_grant;
    int          m_wait;
    logic        rdy;
    int          cycles;

    initial begin
        // Expected grants follow the round-robin rule starting from pointer 0 after reset
        vecs[0] = '{3'b111, 1'b1, 0, 1'b0, 32'h0,        0};
        vecs[1] = '{3'b111, 1'b1, 0, 1'b0, 32'h0,        1};
        vecs[2] = '{3'b111, 1'b1, 0, 1'b0, 32'h0,        2};
        vecs[3] = '{3'b111, 1'b1, 0, 1'b0, 32'h0,        0};
        vecs[4] = '{3'b001, 1'b1, 5, 1'b0, 32'h0,        0};
        vecs[5] = '{3'b100, 1'b0, 0, 1'b1, 32'h55,       2};
        vecs[6] = '{3'b110, 1'b0, 2, 1'b0, 32'h1234,     1};
        vecs[7] = '{3'b011, 1'b0, 1, 1'b0, 32'hCAFE0000, 0};
        vecs[8] = '{3'b101, 1'b0, 0, 1'b0, 32'h77,       2};

        rst_ni = 1'b0;
        clear_inputs();
        set_fixed_payload();
        #2;
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_mst_valid", 64'(mst_valid_o), 64'd0);
        check("rst_mst_addr", 64'(mst_addr_o), 64'd0);
        check("rst_mst_wdata", 64'(mst_wdata_o), 64'd0);
        check("rst_req_ready", 64'(req_ready_o), 64'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // Single read from requester 1, slave answers one cycle after seeing valid
        p_addr[1] = 32'h10;
        apply();
        mst_ready_i = 1'b1;
        mst_rdata_i = 32'h1111;
        #1;
        check("idle_ready_ignored", 64'(req_ready_o), 64'd0);
        mst_ready_i = 1'b0;
        req_valid_i = 3'b010;
        #1;
        check("rd_c0_valid", 64'(mst_valid_o), 64'd0);
        tick();
        check("rd_c1_valid", 64'(mst_valid_o), 64'd1);
        check("rd_c1_addr", 64'(mst_addr_o), 64'h10);
        check("rd_c1_write", 64'(mst_write_o), 64'd0);
        check("rd_c1_rdy", 64'(req_ready_o), 64'd0);
        tick();
        mst_ready_i = 1'b1;
        mst_rdata_i = 32'hDEADBEEF;
        #1;
        check("rd_c2_rdy", 64'(req_ready_o), 64'b010);
        check("rd_c2_rdata", 64'(req_rdata_o), 64'hDEADBEEF);
        tick();
        clear_inputs();
        #1;
        check("rd_c3_busy", 64'(busy_o), 64'd0);
        check("rd_c3_rdata", 64'(req_rdata_o), 64'd0);

        // Requester drops valid while BUSY: completion pulse still appears (pointer now 2)
        req_valid_i = 3'b001;
        tick();
        req_valid_i = 3'b000;
        tick();
        mst_ready_i = 1'b1;
        #1;
        check("drop_rdy", 64'(req_ready_o), 64'b001);
        tick();
        clear_inputs();

        // Table-driven transactions from a fresh reset
        do_reset();
        set_fixed_payload();
        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Reset during a wait state
        req_valid_i = 3'b100;
        tick();
        check("rst_mid_busy_pre", 64'(busy_o), 64'd1);
        tick();
        rst_ni = 1'b0;
        #1;
        check("rst_mid_valid", 64'(mst_valid_o), 64'd0);
        check("rst_mid_busy", 64'(busy_o), 64'd0);
        check("rst_mid_addr", 64'(mst_addr_o), 64'd0);
        req_valid_i = 3'b111;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        check("rst_after_grant", 64'(mst_addr_o), 64'(p_addr[0]));
        mst_ready_i = 1'b1;
        #1;
        check("rst_after_rdy", 64'(req_ready_o), 64'b001);
        tick();
        clear_inputs();

`ifdef PERF_MON_REG_ARB_TIMEOUT_EN
        // Slave never answers: forced error completion, then the next requester is served
        do_reset();
        set_fixed_payload();
        req_valid_i = 3'b011;
        mst_rdata_i = 32'hFFFFFFFF;
        tick();
        cycles = 0;
        while (cycles < 40) begin
            cycles++;
            if (req_ready_o != '0) break;
            tick();
        end
        check("to_cycles", 64'(cycles), 64'd9);
        check("to_rdy", 64'(req_ready_o), 64'b001);
        check("to_err", 64'(req_error_o), 64'd1);
        check("to_rdata", 64'(req_rdata_o), 64'd0);
        tick();
        req_valid_i = 3'b010;
        #1;
        check("to_idle", 64'(busy_o), 64'd0);
        tick();
        check("to_next_grant", 64'(mst_addr_o), 64'(p_addr[1]));
        mst_ready_i = 1'b1;
        mst_error_i = 1'b0;
        #1;
        check("to_next_rdy", 64'(req_ready_o), 64'b010);
        tick();
        clear_inputs();
`endif

        // Random traffic against a transaction-level model
        do_reset();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        m_busy = 1'b0;
        m_rr   = 0;
        m_grant = 0;
        m_wait = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
                    pend[i]    = 1'b1;
                    p_write[i] = 1'($urandom);
                    p_addr[i]  = $urandom;
                    p_wdata[i] = $urandom;
                    p_wstrb[i] = 4'($urandom);
                end
                req_valid_i[i] = pend[i];
            end
            apply();
            rdy = m_busy ? (m_wait == 0) : 1'($urandom);
            mst_ready_i = rdy;
            mst_rdata_i = $urandom;
            mst_error_i = 1'($urandom);
            #1;
            check("rnd_busy", 64'(busy_o), 64'(m_busy));
            check("rnd_valid", 64'(mst_valid_o), 64'(m_busy));
            if (m_busy) begin
                check("rnd_addr", 64'(mst_addr_o), 64'(p_addr[m_grant]));
                check("rnd_wdata", 64'(mst_wdata_o), 64'(p_wdata[m_grant]));
                check("rnd_wstrb", 64'(mst_wstrb_o), 64'(p_wstrb[m_grant]));
                check("rnd_write", 64'(mst_write_o), 64'(p_write[m_grant]));
            end
            if (m_busy && rdy) begin
                check("rnd_rdy", 64'(req_ready_o), 64'(N'(1) << m_grant));
                check("rnd_rdata", 64'(req_rdata_o), 64'(mst_rdata_i));
                check("rnd_err", 64'(req_error_o), 64'(mst_error_i));
            end else begin
                check("rnd_rdy", 64'(req_ready_o), 64'd0);
                check("rnd_rdata", 64'(req_rdata_o), 64'd0);
                check("rnd_err", 64'(req_error_o), 64'd0);
            end
            // Advance the model to the next cycle
            if (m_busy) begin
                if (rdy) begin
                    pend[m_grant] = 1'b0;
                    m_busy = 1'b0;
                    m_rr = (m_grant + 1) % N;
                end else begin
                    m_wait--;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (!m_busy && pend[(m_rr + k) % N]) begin
                        m_busy  = 1'b1;
                        m_grant = (m_rr + k) % N;
                        m_wait  = $urandom_range(0, 3);
                    end
                end
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
